// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI request arbiter: FSM state encoding and owner IDs.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

endpackage

// File: rtl/axi_arb_pick.sv
// Grant selection between the icache and dcache miss ports.
// ARB_ROUND_ROBIN_EN: ties alternate based on last_grant; otherwise data has fixed priority.
module axi_arb_pick
    import axi_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_id
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant_id = ID_INST;
        if (i_req && d_req) begin
            grant_id = ~last_grant;
        end else if (d_req) begin
            grant_id = ID_DATA;
        end
    end
`else
    // Fixed priority only looks at d_req; the remaining inputs are intentionally unused.
    logic unused_pick_inputs;
    assign unused_pick_inputs = last_grant | i_req;

    // Data beats inst whenever data is asking.
    always_comb begin
        grant_id = d_req ? ID_DATA : ID_INST;
    end
`endif

endmodule

// File: rtl/axi_req_arbiter.sv
// Sequencer sharing the single-outstanding AXI bridge between icache and dcache misses.
// Latches one request, issues it over m_req/m_ready, waits for m_done, then acks the owner.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; default build is fixed data priority.
module axi_req_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    input  logic                m_ready,
    output logic                m_id,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_done,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall
);

    state_e state_q, state_d;

    logic                m_req_q, m_id_q, m_we_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [DATA_W/8-1:0] m_wstrb_q;
    logic                i_ack_q, d_ack_q;
    logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

    logic grant_id;
    logic last_grant;
    logic do_grant, do_accept, do_capture;

    axi_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_id   (grant_id)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // Remember who won the most recent arbitration; starts at inst so the first tie goes to data.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_INST;
        end else if (do_grant) begin
            last_grant_q <= grant_id;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = ID_INST;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so the acked requester can drop req.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_req || d_req)      state_d = StIssue;
            StIssue: if (m_req_q && m_ready)  state_d = StWait;
            StWait:  if (m_done)              state_d = StDone;
            StDone:                           state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    // Per-state actions; m_ready and m_done are only honoured in their own states.
    always_comb begin
        do_grant   = (state_q == StIdle) && (i_req || d_req);
        do_accept  = (state_q == StIssue) && m_req_q && m_ready;
        do_capture = (state_q == StWait) && m_done;
    end

    // Request latch, read-data capture and one-cycle acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_q   <= 1'b0;
            m_id_q    <= ID_INST;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            // Ack is high only during DONE, which directly follows the capture cycle.
            i_ack_q <= do_capture && (m_id_q == ID_INST);
            d_ack_q <= do_capture && (m_id_q == ID_DATA);

            if (do_grant) begin
                m_req_q <= 1'b1;
                m_id_q  <= grant_id;
                if (grant_id == ID_DATA) begin
                    m_we_q    <= d_we;
                    m_addr_q  <= d_addr;
                    m_wdata_q <= d_wdata;
                    m_wstrb_q <= d_wstrb;
                end else begin
                    m_we_q    <= 1'b0;
                    m_addr_q  <= i_addr;
                    m_wdata_q <= '0;
                    m_wstrb_q <= '0;
                end
            end

            if (do_accept) begin
                m_req_q <= 1'b0;
            end

            // Writes capture too; the dcache simply ignores d_rdata for stores.
            if (do_capture) begin
                if (m_id_q == ID_INST) begin
                    i_rdata_q <= m_rdata;
                end else begin
                    d_rdata_q <= m_rdata;
                end
            end
        end
    end

    assign m_req   = m_req_q;
    assign m_id    = m_id_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // Stall while any requester is still waiting; forced low during reset.
    assign stall = ~rst & ((i_req & ~i_ack_q) | (d_req & ~d_ack_q));

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Self-checking bench for axi_req_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_axi_req_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLD_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                i_req;
    logic [ADDR_W-1:0]   i_addr;
    logic                i_ack;
    logic [DATA_W-1:0]   i_rdata;
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_ack;
    logic [DATA_W-1:0]   d_rdata;
    logic                m_req;
    logic                m_ready;
    logic                m_id;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_done;
    logic [DATA_W-1:0]   m_rdata;
    logic                stall;

    int nchk = 0;
    int nerr = 0;

    axi_req_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_ready (m_ready),
        .m_id    (m_id),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_done  (m_done),
        .m_rdata (m_rdata),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there before any change.
    task automatic apply_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bridge stand-in: wait for m_req, accept at once, complete at once, return the ack seen.
    task automatic serve(input logic [DATA_W-1:0] rd, output logic got, output logic id,
                         output logic ai, output logic ad);
        got = 1'b0; id = 1'b0; ai = 1'b0; ad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_req) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) return;
        id = m_id;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_done  = 1'b1;
        m_rdata = rd;
        @(negedge clk);
        m_done = 1'b0;
        ai = i_ack;
        ad = d_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; m_ready = 1'b1; m_done = 1'b1;
        i_addr = 32'h1; d_we = 1'b1; d_addr = 32'h2; d_wdata = 32'h3; d_wstrb = 4'hF;
        m_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        nchk++;
        if ({m_req, m_id, m_we, m_addr, m_wdata, m_wstrb, i_ack, d_ack, i_rdata, d_rdata, stall}
            !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: m_req=%b m_id=%b m_we=%b m_addr=%h ack=%b%b stall=%b",
                     m_req, m_id, m_we, m_addr, i_ack, d_ack, stall);
        end
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_done = 1'b0;
        d_we = 1'b0; d_wstrb = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_icache_read();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        #1;
        nchk++;
        if (stall !== 1'b1) begin nerr++; $display("FAIL ic_stall_n: got %b want 1", stall); end
        @(negedge clk);
        nchk++;
        if ({m_req, m_id, m_we, m_addr, m_wdata, m_wstrb, stall} !==
            {1'b1, 1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, 1'b1}) begin
            nerr++;
            $display("FAIL ic_issue: m_req=%b m_id=%b m_we=%b m_addr=%h stall=%b want 1 0 0 bfc00000 1",
                     m_req, m_id, m_we, m_addr, stall);
        end
        m_ready = 1'b1;
        @(negedge clk);
        nchk++;
        if ({m_req, stall, i_ack} !== 3'b010) begin
            nerr++;
            $display("FAIL ic_wait: m_req/stall/i_ack=%b want 010", {m_req, stall, i_ack});
        end
        m_ready = 1'b0; m_done = 1'b1; m_rdata = 32'h3C1D_BFC0;
        @(negedge clk);
        nchk++;
        if ({i_ack, d_ack, stall, i_rdata} !== {3'b100, 32'h3C1D_BFC0}) begin
            nerr++;
            $display("FAIL ic_ack: i_ack=%b d_ack=%b stall=%b i_rdata=%h want 1 0 0 3c1dbfc0",
                     i_ack, d_ack, stall, i_rdata);
        end
        m_done = 1'b0; i_req = 1'b0;
        @(negedge clk);
        nchk++;
        if ({i_ack, i_rdata} !== {1'b0, 32'h3C1D_BFC0}) begin
            nerr++;
            $display("FAIL ic_ack_pulse: i_ack=%b i_rdata=%h want 0 3c1dbfc0", i_ack, i_rdata);
        end
    endtask

    task automatic test_dcache_write_delay();
        logic [FLD_W-1:0] want;
        want = {1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF};
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_1000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            nchk++;
            if ({m_req, m_id, m_we, m_addr, m_wdata, m_wstrb} !== {1'b1, 1'b1, want}) begin
                nerr++;
                $display("FAIL dw_hold%0d: m_req=%b m_id=%b fields=%h want 1 1 %h",
                         k, m_req, m_id, {m_we, m_addr, m_wdata, m_wstrb}, want);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        nchk++;
        if (m_req !== 1'b0) begin nerr++; $display("FAIL dw_accept: m_req=%b want 0", m_req); end
        m_ready = 1'b0; m_done = 1'b1; m_rdata = 32'h0;
        @(negedge clk);
        nchk++;
        if ({d_ack, i_ack} !== 2'b10) begin
            nerr++;
            $display("FAIL dw_ack: d_ack=%b i_ack=%b want 1 0", d_ack, i_ack);
        end
        m_done = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        nchk++;
        if (d_ack !== 1'b0) begin nerr++; $display("FAIL dw_ack_pulse: d_ack=%b want 0", d_ack); end
    endtask

    task automatic test_tie();
        logic got, id, ai, ad;
        apply_reset();
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_wdata = '0; d_wstrb = '0;
        serve(32'h1111_0001, got, id, ai, ad);
        nchk++;
        if ({got, id, ai, ad} !== 4'b1101) begin
            nerr++;
            $display("FAIL tie_first: got/id/i_ack/d_ack=%b want 1101", {got, id, ai, ad});
        end
        if (!RR) d_req = 1'b0;
        serve(32'h1111_0002, got, id, ai, ad);
        nchk++;
        if ({got, id, ai, ad} !== 4'b1010) begin
            nerr++;
            $display("FAIL tie_second: got/id/i_ack/d_ack=%b want 1010", {got, id, ai, ad});
        end
        if (RR) begin
            serve(32'h1111_0003, got, id, ai, ad);
            nchk++;
            if ({got, id, ai, ad} !== 4'b1101) begin
                nerr++;
                $display("FAIL tie_third: got/id/i_ack/d_ack=%b want 1101", {got, id, ai, ad});
            end
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_spurious();
        @(negedge clk);
        m_done = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_ready = 1'b0;
        nchk++;
        if ({m_req, i_ack, d_ack} !== 3'b000) begin
            nerr++;
            $display("FAIL spur_idle: m_req/i_ack/d_ack=%b want 000", {m_req, i_ack, d_ack});
        end
        i_req = 1'b1; i_addr = 32'h0000_4000;
        @(negedge clk);
        m_done = 1'b1; m_rdata = 32'hAAAA_5555;
        @(negedge clk);
        m_done = 1'b0;
        nchk++;
        if ({m_req, i_ack, d_ack, m_addr} !== {3'b100, 32'h0000_4000}) begin
            nerr++;
            $display("FAIL spur_issue: m_req/i_ack/d_ack=%b m_addr=%h want 100 00004000",
                     {m_req, i_ack, d_ack}, m_addr);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0; m_done = 1'b1; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        m_done = 1'b0;
        nchk++;
        if ({i_ack, i_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            nerr++;
            $display("FAIL spur_recover: i_ack=%b i_rdata=%h want 1 0badf00d", i_ack, i_rdata);
        end
        i_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic got, id, ai, ad;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_8000;
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        nchk++;
        if ({m_req, m_id, m_we, m_addr, m_wdata, m_wstrb, i_ack, d_ack, i_rdata, d_rdata, stall}
            !== '0) begin
            nerr++;
            $display("FAIL rst_mid: m_req=%b m_addr=%h i_rdata=%h d_rdata=%h stall=%b want all 0",
                     m_req, m_addr, i_rdata, d_rdata, stall);
        end
        rst = 1'b0;
        serve(32'h5A5A_0001, got, id, ai, ad);
        nchk++;
        if ({got, id, ai, ad, i_rdata} !== {4'b1010, 32'h5A5A_0001}) begin
            nerr++;
            $display("FAIL rst_mid_after: got/id/ia/da=%b i_rdata=%h want 1010 5a5a0001",
                     {got, id, ai, ad}, i_rdata);
        end
        i_req = 1'b0;
    endtask

    task automatic test_rdata_hold();
        logic got, id, ai, ad;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0040;
        serve(32'hC0DE_0001, got, id, ai, ad);
        i_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080; d_wdata = '0; d_wstrb = '0;
        serve(32'hDEAD_BEEF, got, id, ai, ad);
        nchk++;
        if ({got, id, ai, ad, d_rdata, i_rdata} !== {4'b1101, 32'hDEAD_BEEF, 32'hC0DE_0001}) begin
            nerr++;
            $display("FAIL rdata_hold: got/id/ia/da=%b d_rdata=%h i_rdata=%h want 1101 deadbeef c0de0001",
                     {got, id, ai, ad}, d_rdata, i_rdata);
        end
        d_req = 1'b0;
    endtask

    // Random traffic from both requesters against a bridge with random accept/complete delays.
    task automatic test_random();
        int               phase;     // 0 no txn, 1 awaiting accept, 2 awaiting done, 3 ack due
        int               dly, idle_cnt, ntxn;
        logic             own, last_own, pred, exp_ia, exp_da, exp_stall, drop_i, drop_d;
        logic [FLD_W-1:0] fld, cur;
        logic [DATA_W-1:0] exp_rd, i_hold, d_hold;
        apply_reset();
        phase = 0; dly = 0; idle_cnt = 0; ntxn = 0;
        own = 1'b0; last_own = 1'b0; exp_rd = '0; i_hold = '0; d_hold = '0; fld = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            drop_i = 1'b0; drop_d = 1'b0;
            exp_ia = (phase == 3) && (own == 1'b0);
            exp_da = (phase == 3) && (own == 1'b1);
            exp_stall = (i_req & ~exp_ia) | (d_req & ~exp_da);
            cur = {m_we, m_addr, m_wdata, m_wstrb};
            nchk++;
            if ({i_ack, d_ack, stall} !== {exp_ia, exp_da, exp_stall}) begin
                nerr++;
                $display("FAIL rnd_ack_stall c%0d: i_ack/d_ack/stall=%b want %b",
                         cyc, {i_ack, d_ack, stall}, {exp_ia, exp_da, exp_stall});
            end
            if (phase == 3) begin
                m_done = 1'b0;
                if (own == 1'b0) begin i_hold = exp_rd; drop_i = 1'b1; i_req = 1'b0; end
                else begin d_hold = exp_rd; drop_d = 1'b1; d_req = 1'b0; end
                nchk++;
                if ({i_rdata, d_rdata} !== {i_hold, d_hold}) begin
                    nerr++;
                    $display("FAIL rnd_rdata c%0d: i_rdata=%h d_rdata=%h want %h %h",
                             cyc, i_rdata, d_rdata, i_hold, d_hold);
                end
                ntxn++;
                phase = 0;
            end else if (phase == 2) begin
                m_ready = 1'b0;
                nchk++;
                if (m_req !== 1'b0) begin
                    nerr++;
                    $display("FAIL rnd_req_drop c%0d: m_req=%b want 0", cyc, m_req);
                end
                if (dly == 0) begin
                    m_done = 1'b1; m_rdata = $urandom; exp_rd = m_rdata; phase = 3;
                end else begin
                    dly--;
                end
            end
            if (phase == 0) begin
                if (m_req) begin
                    if (i_req && d_req) pred = RR ? ~last_own : 1'b1;
                    else pred = d_req;
                    fld = pred ? {d_we, d_addr, d_wdata, d_wstrb} : {1'b0, i_addr, 32'h0, 4'h0};
                    nchk++;
                    if ({m_id, cur} !== {pred, fld} || idle_cnt > 2) begin
                        nerr++;
                        $display("FAIL rnd_grant c%0d: m_id=%b fields=%h wait=%0d want %b %h <=2",
                                 cyc, m_id, cur, idle_cnt, pred, fld);
                    end
                    own = pred; last_own = pred; idle_cnt = 0;
                    dly = int'($urandom_range(0, 3));
                    phase = 1;
                end else if (i_req || d_req) begin
                    idle_cnt++;
                    if (idle_cnt > 8) begin
                        nchk++; nerr++;
                        $display("FAIL rnd_no_grant c%0d: m_req=0 after %0d cycles", cyc, idle_cnt);
                        idle_cnt = 0;
                    end
                end
            end else if (phase == 1) begin
                nchk++;
                if ({m_req, m_id, cur} !== {1'b1, own, fld}) begin
                    nerr++;
                    $display("FAIL rnd_hold c%0d: m_req=%b m_id=%b fields=%h want 1 %b %h",
                             cyc, m_req, m_id, cur, own, fld);
                end
                if (dly == 0) begin
                    m_ready = 1'b1; dly = int'($urandom_range(0, 3)); phase = 2;
                end else begin
                    dly--;
                end
            end
            if (!i_req && !drop_i && ($urandom % 3 == 0)) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (!d_req && !drop_d && ($urandom % 3 == 0)) begin
                d_req = 1'b1; d_we = 1'($urandom % 2); d_addr = $urandom;
                d_wdata = $urandom; d_wstrb = 4'($urandom);
            end
        end
        nchk++;
        if (ntxn < 50) begin
            nerr++;
            $display("FAIL rnd_progress: %0d transactions completed, want at least 50", ntxn);
        end
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write_delay();
        test_tie();
        test_spurious();
        test_reset_mid();
        test_rdata_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
